reg_file_mp: RTL and testbench
==============================

// Module: reg_file_mp
// PURPOSE
//  Parametrised multi-read-port register file for the micro_mips datapath.
//  Registered reads with a 1-cycle latency. Reads and writes may occur in the same cycle.
//  Entry 0 can be hardwired to zero. A sequenced clear sweep zeroes the array without a reset.
//  Replaces the fixed 32x32, 2-read, read-or-write register file in the decode stage.
// PARAMETERS
//  DATA_W   32  data width of every entry
//  ADDR_W    5  address width; depth = 2**ADDR_W entries
//  NRD       2  number of read ports (>=1)
//  ZERO_R0   1  1: entry 0 reads as 0 and writes to it are dropped; 0: normal entry
// PORTS
//  clk    in   1            clock; all state updates on its rising edge
//  res    in   1            asynchronous, active-low reset
//  re     in   1            read enable, shared by all read ports
//  ra     in   NRD*ADDR_W   read addresses; port k = ra[k*ADDR_W +: ADDR_W]
//  rd     out  NRD*DATA_W   read data; port k = rd[k*DATA_W +: DATA_W]
//  rd_vld out  1            rd carries the data of a read issued the previous cycle
//  we     in   1            write enable
//  wa     in   ADDR_W       write address
//  wd     in   DATA_W       write data
//  clr    in   1            start clear sweep (1-cycle pulse, level tolerated)
//  busy   out  1            clear sweep in progress
// BEHAVIOUR
//  - Reset (res=0, async): ALL 2**ADDR_W entries = 0, rd = 0, rd_vld = 0, busy = 0, FSM = IDLE,
//    sweep pointer = 0. Reset mid-sweep aborts the sweep; the array is zero anyway.
//  - Read: when re=1 at edge N, rd[k] = mem[ra[k]] after edge N, and rd_vld = 1.
//    When re=0, rd holds its last value and rd_vld = 0 after the edge.
//  - ZERO_R0=1: a read of address 0 returns 0, regardless of collisions or bypass.
//  - Write: we=1 and busy=0 at an edge -> mem[wa] = wd. Any read/write mix is legal in one cycle.
//  - Read/write collision (re=1, we=1, ra[k]==wa, wa accepted):
//    see CONFIGURATION; each port resolves the collision independently.
//  - Multiple read ports on the same address each return identical data.
//  - FSM IDLE: clr=1 -> SWEEP; ptr = 0; busy = 1 from the next cycle.
//  - FSM SWEEP: each cycle mem[ptr] = 0 and ptr += 1. After ptr = 2**ADDR_W-1 is written -> IDLE,
//    busy = 0. The sweep takes exactly 2**ADDR_W cycles.
//  - During busy: we is ignored and the write is lost (no queueing). clr is ignored. re still works.
//    A read returns the pre-sweep value for entries not yet cleared and 0 for cleared entries.
//    A same-cycle read of the entry being cleared returns the old value.
//  - A clr arriving in the same cycle as an accepted we: the write is applied, then the sweep starts.
// CONFIGURATION
//  Macro RF_BYPASS_EN:
//   - Defined: write-through forwarding. On a collision, rd[k] = wd in the same latency.
//     Forwarding applies only to accepted external writes, never to sweep clears.
//   - Undefined: read-before-write. On a collision, rd[k] = the old mem[wa].
//     The new value is visible to reads issued from the next cycle on.
// TESTING
//  1. Reset, then re=1 with ra = {5,0} -> next cycle rd = {0,0}, rd_vld = 1. Re-read all 32 entries -> all 0, last entry included.
//  2. Write 0xDEADBEEF to entry 9, then read 9 on both ports -> rd = {DEADBEEF,DEADBEEF} 1 cycle later. Write 0x1234 to entry 0 -> reads 0 (ZERO_R0=1).
//  3. Entry 7 = 0x11; same cycle: we wa=7 wd=0x22, re ra[0]=7 -> rd[0] = 0x22 with RF_BYPASS_EN, 0x11 without. A later read returns 0x22 in both builds.
//  4. Fill entries 1..31 with their own index; pulse clr -> busy high for exactly 32 cycles. A we during busy is dropped. All reads return 0 afterward.
//  5. Start a sweep, assert res=0 at sweep cycle 10 -> busy = 0 and rd_vld = 0 immediately. After release, all entries = 0 and a new clr is accepted.
//  6. re=0 for 3 cycles after a read of 0xAB -> rd holds 0xAB and rd_vld = 0 throughout.

Source files
------------

// File: rtl/reg_file_mp.sv
// ---------------------------------------------------------------------------
// reg_file_mp
//   Parametrised multi-read-port register file for the micro_mips decode
//   stage. Every read port is registered (one cycle of latency) and shares a
//   single read enable. Reads and writes may happen in the same cycle. Entry 0
//   can be hardwired to zero. A clear sweep zeroes the whole array one entry
//   per cycle without needing a reset.
//
//   Optional feature macro: RF_BYPASS_EN
//     defined   : write-through forwarding on a read/write collision
//     undefined : read-before-write (the collision returns the old contents)
//
// Parameters
//   DATA_W   data width of every entry
//   ADDR_W   address width, depth = 2**ADDR_W
//   NRD      number of read ports (>= 1)
//   ZERO_R0  1: entry 0 reads as zero and writes to it are dropped
//
// Ports
//   clk_i      clock, rising edge
//   rst_ni     asynchronous active-low reset
//   re_i       read enable for all read ports
//   ra_i       read addresses, port k = ra_i[k*ADDR_W +: ADDR_W]
//   rd_o       read data,      port k = rd_o[k*DATA_W +: DATA_W]
//   rd_vld_o   rd_o holds data of a read issued on the previous cycle
//   we_i       write enable (ignored while busy_o is high)
//   wa_i       write address
//   wd_i       write data
//   clr_i      start a clear sweep
//   busy_o     clear sweep in progress
// ---------------------------------------------------------------------------
module reg_file_mp #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 5,
   parameter int NRD     = 2,
   parameter int ZERO_R0 = 1
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    re_i,
   input  logic [NRD*ADDR_W-1:0]   ra_i,
   output logic [NRD*DATA_W-1:0]   rd_o,
   output logic                    rd_vld_o,
   input  logic                    we_i,
   input  logic [ADDR_W-1:0]       wa_i,
   input  logic [DATA_W-1:0]       wd_i,
   input  logic                    clr_i,
   output logic                    busy_o
);

   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic {
      IDLE,
      SWEEP
   } state_t;

   state_t                  state_q, state_d;
   logic [ADDR_W-1:0]       ptr_q, ptr_d;
   logic [DATA_W-1:0]       mem_q [DEPTH];
   logic [NRD*DATA_W-1:0]   rd_q, rd_d;
   logic                    rdVld_q;
   logic                    wrAccept;

   // External writes are only accepted while no sweep is running; a write
   // presented during a sweep is simply lost.
   assign wrAccept = we_i && (state_q == IDLE);
   assign busy_o   = (state_q == SWEEP);
   assign rd_o     = rd_q;
   assign rd_vld_o = rdVld_q;

   // Sweep sequencer: a clear request in IDLE starts the sweep at entry 0, and
   // the sweep returns to IDLE right after the last entry has been cleared, so
   // it occupies exactly DEPTH cycles. Requests during a sweep are ignored.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      case (state_q)
         IDLE: begin
            if (clr_i) begin
               state_d = SWEEP;
               ptr_d   = '0;
            end
         end
         SWEEP: begin
            ptr_d = ptr_q + ADDR_W'(1);
            if (ptr_q == '1) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            ptr_d   = '0;
         end
      endcase
   end

   // Sequencer state register; reset aborts any sweep in flight.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   // Storage array. The sweep owns the write path while it runs; otherwise an
   // accepted write lands at wa_i, except that entry 0 is kept at zero when it
   // is hardwired. A clear request in the same cycle as an accepted write lets
   // the write land first, since the sweep only starts on the next cycle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (state_q == SWEEP) begin
         mem_q[ptr_q] <= '0;
      end else if (wrAccept && !((ZERO_R0 != 0) && (wa_i == '0))) begin
         mem_q[wa_i] <= wd_i;
      end
   end

   // Read data selection, resolved independently for every port. The array
   // is read before this cycle's update, so a collision naturally returns the
   // old contents and an entry being swept still shows its old value. With
   // forwarding enabled, an accepted external write to the same address wins
   // instead. A hardwired entry 0 overrides everything. When re_i is low the
   // previous data is held.
   always_comb begin
      rd_d = rd_q;
      if (re_i) begin
         for (int k = 0; k < NRD; k++) begin
            rd_d[k*DATA_W +: DATA_W] = mem_q[ra_i[k*ADDR_W +: ADDR_W]];
`ifdef RF_BYPASS_EN
            if (wrAccept && (ra_i[k*ADDR_W +: ADDR_W] == wa_i)) begin
               rd_d[k*DATA_W +: DATA_W] = wd_i;
            end
`endif
            if ((ZERO_R0 != 0) && (ra_i[k*ADDR_W +: ADDR_W] == '0)) begin
               rd_d[k*DATA_W +: DATA_W] = '0;
            end
         end
      end
   end

   // Output registers: data updates only on a read, valid flags every cycle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_q    <= '0;
         rdVld_q <= 1'b0;
      end else begin
         rd_q    <= rd_d;
         rdVld_q <= re_i;
      end
   end

endmodule

// File: tb/tb_reg_file_mp.sv
// ---------------------------------------------------------------------------
// tb_reg_file_mp
//   Self-checking bench for reg_file_mp with default parameters
//   (32 x 32 bit, 2 read ports, entry 0 hardwired to zero). A behavioural
//   model tracks the array contents and the sweep progress, and a compare
//   process checks every cycle. Directed scenarios pin the model with literal
//   expectations, then a randomized phase stresses collisions and sweeps.
//   Honours RF_BYPASS_EN in the same way as the design.
// ---------------------------------------------------------------------------
module tb_reg_file_mp;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int NRD    = 2;
   localparam int DEPTH  = 32;

`ifdef RF_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b1;
   logic                  re = 1'b0;
   logic [NRD*ADDR_W-1:0] ra = '0;
   logic                  we = 1'b0;
   logic [ADDR_W-1:0]     wa = '0;
   logic [DATA_W-1:0]     wd = '0;
   logic                  clr = 1'b0;
   logic [NRD*DATA_W-1:0] rd;
   logic                  rdVld;
   logic                  busy;

   int assertCount = 0;
   int failCount   = 0;
   bit checkEn     = 1'b0;

   reg_file_mp #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .NRD    (NRD),
      .ZERO_R0(1)
   ) dut (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .re_i    (re),
      .ra_i    (ra),
      .rd_o    (rd),
      .rd_vld_o(rdVld),
      .we_i    (we),
      .wa_i    (wa),
      .wd_i    (wd),
      .clr_i   (clr),
      .busy_o  (busy)
   );

   always #5 clk = ~clk;

   // Reference model state: array contents, expected read outputs, and the
   // number of entries the running sweep has already cleared.
   logic [DATA_W-1:0] modelMem [DEPTH];
   logic [DATA_W-1:0] expRd [NRD];
   logic              expVld;
   bit                modelSweeping;
   int                sweepDone;
   bit                mAccept;
   int                mAddr;

   // Behavioural model: reads see the array as it was before this edge, then
   // the sweep or the accepted write updates it.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) modelMem[i] = '0;
         for (int k = 0; k < NRD; k++) expRd[k] = '0;
         expVld        = 1'b0;
         modelSweeping = 1'b0;
         sweepDone     = 0;
      end else begin
         mAccept = we && !modelSweeping;
         if (re) begin
            for (int k = 0; k < NRD; k++) begin
               mAddr = int'(ra[k*ADDR_W +: ADDR_W]);
               if (mAddr == 0)
                  expRd[k] = '0;
               else if (BYPASS && mAccept && (mAddr == int'(wa)))
                  expRd[k] = wd;
               else
                  expRd[k] = modelMem[mAddr];
            end
         end
         expVld = re;
         if (modelSweeping) begin
            modelMem[sweepDone] = '0;
            sweepDone = sweepDone + 1;
            if (sweepDone == DEPTH) modelSweeping = 1'b0;
         end else begin
            if (mAccept && (wa != '0)) modelMem[wa] = wd;
            if (clr) begin
               modelSweeping = 1'b1;
               sweepDone     = 0;
            end
         end
      end
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      assertCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (checkEn && rst_n) begin
         checkOutput("model rd_vld", 64'(rdVld), 64'(expVld));
         checkOutput("model rd", 64'(rd), {expRd[1], expRd[0]});
         checkOutput("model busy", 64'(busy), 64'(modelSweeping));
      end
   end

   // Drive one cycle of inputs and return at the following falling edge.
   task automatic applyStimulus(input logic r, input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                                input logic w, input logic [ADDR_W-1:0] waddr,
                                input logic [DATA_W-1:0] wdata, input logic c);
      re  = r;
      ra  = {a1, a0};
      we  = w;
      wa  = waddr;
      wd  = wdata;
      clr = c;
      @(negedge clk);
   endtask

   task automatic idle();
      applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
   endtask

   int cnt;
   logic [ADDR_W-1:0] rA, rB, wA;

   initial begin
      // Initial reset
      #1 rst_n = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      checkEn = 1'b1;
      checkOutput("reset rd", 64'(rd), 64'h0);
      checkOutput("reset rd_vld", 64'(rdVld), 64'h0);
      checkOutput("reset busy", 64'(busy), 64'h0);

      // Scenario 1: read after reset, then every entry
      applyStimulus(1'b1, 5'd0, 5'd5, 1'b0, '0, '0, 1'b0);
      checkOutput("first read rd", 64'(rd), 64'h0);
      checkOutput("first read rd_vld", 64'(rdVld), 64'h1);
      for (int i = 0; i < DEPTH; i++)
         applyStimulus(1'b1, 5'(i), 5'(DEPTH - 1 - i), 1'b0, '0, '0, 1'b0);
      checkOutput("post-reset entry 31", 64'(rd[31:0]), 64'h0);

      // Scenario 2: plain write/read and the hardwired entry 0
      applyStimulus(1'b0, '0, '0, 1'b1, 5'd9, 32'hDEADBEEF, 1'b0);
      applyStimulus(1'b1, 5'd9, 5'd9, 1'b0, '0, '0, 1'b0);
      checkOutput("entry 9 both ports", 64'(rd), 64'hDEADBEEF_DEADBEEF);
      applyStimulus(1'b0, '0, '0, 1'b1, 5'd0, 32'h1234, 1'b0);
      applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, '0, '0, 1'b0);
      checkOutput("entry 0 stays zero", 64'(rd), 64'h0);

      // Scenario 3: read/write collision
      applyStimulus(1'b0, '0, '0, 1'b1, 5'd7, 32'h11, 1'b0);
      applyStimulus(1'b1, 5'd7, 5'd3, 1'b1, 5'd7, 32'h22, 1'b0);
      checkOutput("collision port0", 64'(rd[31:0]), BYPASS ? 64'h22 : 64'h11);
      applyStimulus(1'b1, 5'd7, 5'd7, 1'b0, '0, '0, 1'b0);
      checkOutput("after collision", 64'(rd), 64'h00000022_00000022);

      // Scenario 4: fill, sweep, dropped write, clear result
      for (int i = 1; i < DEPTH; i++)
         applyStimulus(1'b0, '0, '0, 1'b1, 5'(i), 32'(i), 1'b0);
      applyStimulus(1'b1, 5'd20, 5'd31, 1'b0, '0, '0, 1'b1);
      checkOutput("pre-sweep entry 20", 64'(rd[31:0]), 64'd20);
      cnt = 0;
      while (busy && cnt < 100) begin
         cnt++;
         applyStimulus(1'b1, 5'($urandom_range(0, 31)), 5'd31, cnt == 3, 5'd5, 32'hFFFF, cnt == 6);
      end
      checkOutput("sweep length", 64'(cnt), 64'd32);
      applyStimulus(1'b1, 5'd5, 5'd31, 1'b0, '0, '0, 1'b0);
      checkOutput("dropped write entry 5", 64'(rd), 64'h0);
      for (int i = 0; i < DEPTH; i++)
         applyStimulus(1'b1, 5'(i), 5'(i), 1'b0, '0, '0, 1'b0);

      // Scenario 5: reset in the middle of a sweep
      for (int i = 1; i < 5; i++)
         applyStimulus(1'b0, '0, '0, 1'b1, 5'(i), 32'hA0 + 32'(i), 1'b0);
      applyStimulus(1'b1, 5'd4, 5'd3, 1'b0, '0, '0, 1'b1);
      for (int i = 0; i < 10; i++)
         applyStimulus(1'b1, 5'd4, 5'd30, 1'b0, '0, '0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("mid-sweep reset busy", 64'(busy), 64'h0);
      checkOutput("mid-sweep reset rd_vld", 64'(rdVld), 64'h0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      re = 1'b0;
      @(negedge clk);
      applyStimulus(1'b1, 5'd4, 5'd3, 1'b0, '0, '0, 1'b0);
      checkOutput("entries 3/4 after reset", 64'(rd), 64'h0);
      for (int i = 0; i < DEPTH; i++)
         applyStimulus(1'b1, 5'(i), 5'(i), 1'b0, '0, '0, 1'b0);
      applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
      checkOutput("new clr accepted", 64'(busy), 64'h1);
      cnt = 0;
      while (busy && cnt < 100) begin
         cnt++;
         idle();
      end
      checkOutput("second sweep length", 64'(cnt), 64'd32);

      // Scenario 6: read data holds while re is low
      applyStimulus(1'b0, '0, '0, 1'b1, 5'd3, 32'hAB, 1'b0);
      applyStimulus(1'b1, 5'd3, 5'd3, 1'b0, '0, '0, 1'b0);
      checkOutput("read 0xAB", 64'(rd[31:0]), 64'hAB);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 5'(i + 10), 5'(i), 1'b0, '0, '0, 1'b0);
         checkOutput("hold rd", 64'(rd[31:0]), 64'hAB);
         checkOutput("hold rd_vld", 64'(rdVld), 64'h0);
      end

      // Randomized phase, biased toward collisions
      for (int i = 0; i < 600; i++) begin
         wA = 5'($urandom_range(0, 31));
         rA = ($urandom_range(0, 1) == 1) ? wA : 5'($urandom_range(0, 31));
         rB = ($urandom_range(0, 3) == 0) ? rA : 5'($urandom_range(0, 31));
         applyStimulus($urandom_range(0, 3) != 0, rA, rB, $urandom_range(0, 1) == 1,
                       wA, $urandom, $urandom_range(0, 60) == 0);
      end
      idle();

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
